// File: rtl/rob_scalable.sv
// rob_scalable
// Parametrised reorder buffer. Dispatched instructions enter at the tail in
// program order. Completions arrive over the CDB ports and mark entries done.
// Retire drains the head. A branch flush restores the tail pointer.
// Head and tail carry a phase bit above the slot index, so a full buffer
// (equal index, different phase) is never confused with an empty one.
//
// Optional feature macro: ROB_EXCEPTION_EN
//   When defined, this adds the cdb_exc input and the retire_exc output.
//   An excepting entry ends the retire window. It is included in the window.
//
// Ports:
//   clock, reset    rising-edge clock, synchronous active-high reset
//   disp_count      number of dispatch lanes used this cycle (lane 0 oldest)
//   disp_payload    WIDTH packed dispatch payloads
//   disp_spots      free slots, capped at WIDTH
//   disp_tail       pointer that lane 0 lands on; lane i lands on disp_tail+i
//   cdb_valid       per-port completion strobe
//   cdb_idx         per-port completing slot index
//   cdb_exc         per-port exception flag (ROB_EXCEPTION_EN only)
//   retire_avail    completed entries at the head, capped at WIDTH
//   retire_exc      the retire window ends on an excepting entry (ROB_EXCEPTION_EN only)
//   retire_payload  payloads at the head; lanes past retire_avail read zero
//   retire_count    entries retired this cycle
//   flush_valid     tail restore strobe
//   flush_tail      restored tail pointer
//   count           current occupancy
module rob_scalable #(
   parameter int DEPTH     = 32,
   parameter int WIDTH     = 3,
   parameter int CDB_PORTS = 2,
   parameter int PAYLOAD_W = 64,
   localparam int IDX_W    = $clog2(DEPTH),
   localparam int PTR_W    = IDX_W + 1,
   localparam int CNT_W    = $clog2(WIDTH + 1)
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [CNT_W-1:0]           disp_count,
   input  logic [WIDTH*PAYLOAD_W-1:0] disp_payload,
   output logic [CNT_W-1:0]           disp_spots,
   output logic [PTR_W-1:0]           disp_tail,
   input  logic [CDB_PORTS-1:0]       cdb_valid,
   input  logic [CDB_PORTS*IDX_W-1:0] cdb_idx,
`ifdef ROB_EXCEPTION_EN
   input  logic [CDB_PORTS-1:0]       cdb_exc,
   output logic                       retire_exc,
`endif
   output logic [CNT_W-1:0]           retire_avail,
   output logic [WIDTH*PAYLOAD_W-1:0] retire_payload,
   input  logic [CNT_W-1:0]           retire_count,
   input  logic                       flush_valid,
   input  logic [PTR_W-1:0]           flush_tail,
   output logic [IDX_W:0]             count
);

   logic [PAYLOAD_W-1:0] payload_q [DEPTH];
   logic [DEPTH-1:0]     done_q;
`ifdef ROB_EXCEPTION_EN
   logic [DEPTH-1:0]     exc_q;
`endif
   logic [PTR_W-1:0]     head_q;
   logic [PTR_W-1:0]     tail_q;
   logic [IDX_W-1:0]     head_idx;
   logic [IDX_W-1:0]     tail_idx;
   logic [PTR_W:0]       free_slots;
   logic [IDX_W-1:0]     win_slot;
   logic                 win_stop;
   logic [IDX_W-1:0]     rd_slot;

   // Occupancy is the modular pointer distance. The phase bit makes
   // tail == head + DEPTH read as a full buffer rather than an empty one.
   assign count     = tail_q - head_q;
   assign disp_tail = tail_q;
   assign head_idx  = head_q[IDX_W-1:0];
   assign tail_idx  = tail_q[IDX_W-1:0];

   // Dispatch credit is the free space, capped at WIDTH.
   // It is computed from registered state only, so a retire in the same
   // cycle does not add credit until the following cycle.
   always_comb begin
      free_slots = (PTR_W+1)'(DEPTH) - {1'b0, count};
      if (free_slots >= (PTR_W+1)'(WIDTH)) begin
         disp_spots = CNT_W'(WIDTH);
      end else begin
         disp_spots = CNT_W'(free_slots);
      end
   end

   // Walk forward from the head and count the run of completed entries.
   // The walk stops at the first entry that is not done, at the occupancy,
   // or at the lane width. With exceptions enabled, the walk also stops
   // just after an excepting entry. That entry is included, so retire sees
   // it at the end of the window.
   always_comb begin
      retire_avail = '0;
      win_stop     = 1'b0;
      win_slot     = '0;
`ifdef ROB_EXCEPTION_EN
      retire_exc   = 1'b0;
`endif
      for (int i = 0; i < WIDTH; i++) begin
         win_slot = head_idx + IDX_W'(i);
         if (!win_stop && (PTR_W'(i) < count) && done_q[win_slot]) begin
            retire_avail = retire_avail + CNT_W'(1);
`ifdef ROB_EXCEPTION_EN
            if (exc_q[win_slot]) begin
               win_stop   = 1'b1;
               retire_exc = 1'b1;
            end
`endif
         end else begin
            win_stop = 1'b1;
         end
      end
   end

   // Present the head payloads for the retire window only.
   // Lanes past retire_avail are driven to zero so stale data never leaks out.
   always_comb begin
      retire_payload = '0;
      rd_slot        = '0;
      for (int i = 0; i < WIDTH; i++) begin
         rd_slot = head_idx + IDX_W'(i);
         if (CNT_W'(i) < retire_avail) begin
            retire_payload[i*PAYLOAD_W +: PAYLOAD_W] = payload_q[rd_slot];
         end
      end
   end

   // Pointer and storage update.
   // Retire always advances the head, even during a flush.
   // A flush replaces the tail and drops any same-cycle dispatch.
   // CDB writes land first and dispatch clears follow, so a freshly
   // allocated slot always starts out not done.
   // Retired done bits are left alone; the next dispatch into that slot
   // clears them.
   always_ff @(posedge clock) begin
      if (reset) begin
         head_q <= '0;
         tail_q <= '0;
         done_q <= '0;
`ifdef ROB_EXCEPTION_EN
         exc_q  <= '0;
`endif
         for (int i = 0; i < DEPTH; i++) begin
            payload_q[i] <= '0;
         end
      end else begin
         head_q <= head_q + PTR_W'(retire_count);
         tail_q <= flush_valid ? flush_tail : tail_q + PTR_W'(disp_count);
         for (int p = 0; p < CDB_PORTS; p++) begin
            if (cdb_valid[p]) begin
               done_q[cdb_idx[p*IDX_W +: IDX_W]] <= 1'b1;
`ifdef ROB_EXCEPTION_EN
               if (cdb_exc[p]) begin
                  exc_q[cdb_idx[p*IDX_W +: IDX_W]] <= 1'b1;
               end
`endif
            end
         end
         for (int i = 0; i < WIDTH; i++) begin
            if (!flush_valid && (CNT_W'(i) < disp_count)) begin
               payload_q[tail_idx + IDX_W'(i)] <= disp_payload[i*PAYLOAD_W +: PAYLOAD_W];
               done_q[tail_idx + IDX_W'(i)]    <= 1'b0;
`ifdef ROB_EXCEPTION_EN
               exc_q[tail_idx + IDX_W'(i)]     <= 1'b0;
`endif
            end
         end
      end
   end

   // Protocol checks for the surrounding pipeline: no over-dispatch, no
   // retire beyond the ready window, and a flush target that lies between
   // head and tail.
   a_disp_overflow: assert property (@(posedge clock) disable iff (reset)
      disp_count <= disp_spots);
   a_retire_overrun: assert property (@(posedge clock) disable iff (reset)
      retire_count <= retire_avail);
   a_flush_range: assert property (@(posedge clock) disable iff (reset)
      !flush_valid || (PTR_W'(flush_tail - head_q) <= count));

endmodule

// File: tb/tb_rob_scalable.sv
// tb_rob_scalable
// Directed and random stimulus for rob_scalable with DEPTH=8, WIDTH=3,
// CDB_PORTS=2 and PAYLOAD_W=16.
// The reference model tracks head and tail as unbounded integer sequence
// numbers. It keeps per-slot done/exception flags and payloads, and derives
// every expected output from them.
module tb_rob_scalable;

   localparam int D   = 8;
   localparam int W   = 3;
   localparam int CP  = 2;
   localparam int PW  = 16;
   localparam int IW  = 3;
   localparam int PTW = 4;
   localparam int CW  = 2;

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic [CW-1:0]   disp_count = '0;
   logic [W*PW-1:0] disp_payload = '0;
   logic [CW-1:0]   disp_spots;
   logic [PTW-1:0]  disp_tail;
   logic [CP-1:0]   cdb_valid = '0;
   logic [CP*IW-1:0] cdb_idx = '0;
   logic [CP-1:0]   cdb_exc = '0;
   logic            retire_exc;
   logic [CW-1:0]   retire_avail;
   logic [W*PW-1:0] retire_payload;
   logic [CW-1:0]   retire_count = '0;
   logic            flush_valid = 1'b0;
   logic [PTW-1:0]  flush_tail = '0;
   logic [IW:0]     count;

   int              cmp_n = 0;
   int              err_n = 0;

   int              m_head = 0;
   int              m_tail = 0;
   bit              m_done [D];
   bit              m_exc  [D];
   logic [PW-1:0]   m_pay  [D];

   rob_scalable #(
      .DEPTH(D), .WIDTH(W), .CDB_PORTS(CP), .PAYLOAD_W(PW)
   ) dut (
      .clock(clock),
      .reset(reset),
      .disp_count(disp_count),
      .disp_payload(disp_payload),
      .disp_spots(disp_spots),
      .disp_tail(disp_tail),
      .cdb_valid(cdb_valid),
      .cdb_idx(cdb_idx),
`ifdef ROB_EXCEPTION_EN
      .cdb_exc(cdb_exc),
      .retire_exc(retire_exc),
`endif
      .retire_avail(retire_avail),
      .retire_payload(retire_payload),
      .retire_count(retire_count),
      .flush_valid(flush_valid),
      .flush_tail(flush_tail),
      .count(count)
   );

`ifndef ROB_EXCEPTION_EN
   assign retire_exc = 1'b0;
`endif

   // Free-running clock with a 10-unit period.
   always #5 clock = ~clock;

   // Model queries, computed directly from the buffer rules.
   function automatic int m_count();
      return m_tail - m_head;
   endfunction

   function automatic int m_spots();
      return (D - m_count() < W) ? D - m_count() : W;
   endfunction

   function automatic int m_avail();
      int a = 0;
      for (int k = 0; k < W && k < m_count(); k++) begin
         if (!m_done[(m_head + k) % D]) break;
         a++;
         if (m_exc[(m_head + k) % D]) break;
      end
      return a;
   endfunction

   function automatic bit m_exc_win();
      int a = m_avail();
      return (a > 0) && m_exc[(m_head + a - 1) % D];
   endfunction

   // Compare one DUT value against a fixed scenario value.
   task automatic checkConst(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      cmp_n++;
      assert (obs === exp) else begin
         err_n++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Compare every output against the model state.
   task automatic checkOutput();
      int c;
      int a;
      logic [W*PW-1:0] ep;
      c  = m_count();
      a  = m_avail();
      ep = '0;
      for (int k = 0; k < a; k++) ep[k*PW +: PW] = m_pay[(m_head + k) % D];
      cmp_n++;
      assert (count === (IW+1)'(c)) else begin
         err_n++;
         $error("[TB] FAIL count: observed %0d expected %0d", count, c);
      end
      cmp_n++;
      assert (disp_spots === CW'(m_spots())) else begin
         err_n++;
         $error("[TB] FAIL disp_spots: observed %0d expected %0d", disp_spots, m_spots());
      end
      cmp_n++;
      assert (disp_tail === PTW'(m_tail % (2*D))) else begin
         err_n++;
         $error("[TB] FAIL disp_tail: observed %0d expected %0d", disp_tail, m_tail % (2*D));
      end
      cmp_n++;
      assert (retire_avail === CW'(a)) else begin
         err_n++;
         $error("[TB] FAIL retire_avail: observed %0d expected %0d", retire_avail, a);
      end
      cmp_n++;
      assert (retire_payload === ep) else begin
         err_n++;
         $error("[TB] FAIL retire_payload: observed %h expected %h", retire_payload, ep);
      end
`ifdef ROB_EXCEPTION_EN
      cmp_n++;
      assert (retire_exc === m_exc_win()) else begin
         err_n++;
         $error("[TB] FAIL retire_exc: observed %0d expected %0d", retire_exc, m_exc_win());
      end
`endif
   endtask

   // Drive one cycle of inputs, clock it, advance the model, then check.
   // fk is the number of entries, counted from the current head, that a
   // flush keeps.
   task automatic applyStimulus(input int dc, input int rc, input bit fv, input int fk,
                                input bit [1:0] cv, input int ci0, input int ci1, input bit rst);
      logic [PW-1:0] lane [W];
      int old_head;
      reset = rst;
      disp_count = CW'(dc);
      for (int i = 0; i < W; i++) begin
         lane[i] = PW'($urandom);
         disp_payload[i*PW +: PW] = lane[i];
      end
      retire_count = CW'(rc);
      flush_valid  = fv;
      flush_tail   = PTW'((m_head + fk) % (2*D));
      cdb_valid    = cv;
      cdb_idx      = {IW'(ci1), IW'(ci0)};
      @(posedge clock);
      #1;
      if (rst) begin
         m_head = 0;
         m_tail = 0;
         for (int s = 0; s < D; s++) begin
            m_done[s] = 0;
            m_exc[s]  = 0;
            m_pay[s]  = '0;
         end
      end else begin
         if (cv[0]) begin
            m_done[ci0] = 1;
            if (cdb_exc[0]) m_exc[ci0] = 1;
         end
         if (cv[1]) begin
            m_done[ci1] = 1;
            if (cdb_exc[1]) m_exc[ci1] = 1;
         end
         if (!fv) begin
            for (int i = 0; i < dc; i++) begin
               m_pay[(m_tail + i) % D]  = lane[i];
               m_done[(m_tail + i) % D] = 0;
               m_exc[(m_tail + i) % D]  = 0;
            end
         end
         old_head = m_head;
         m_head = m_head + rc;
         m_tail = fv ? old_head + fk : m_tail + dc;
      end
      reset        = 1'b0;
      disp_count   = '0;
      retire_count = '0;
      flush_valid  = 1'b0;
      cdb_valid    = '0;
      checkOutput();
   endtask

   initial begin
      // Reset, then idle.
      applyStimulus(0, 0, 0, 0, 2'b00, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 2'b00, 0, 0, 1);
      checkConst("reset_spots", 32'(disp_spots), 3);
      applyStimulus(0, 0, 0, 0, 2'b00, 0, 0, 0);
      checkConst("idle_spots", 32'(disp_spots), 3);
      checkConst("idle_tail", 32'(disp_tail), 0);
      checkConst("idle_avail", 32'(retire_avail), 0);
      checkConst("idle_count", 32'(count), 0);

      // Fill to full with capped dispatch: lane counts 3, 3, 2.
      for (int n = 0; n < 3; n++) applyStimulus(m_spots(), 0, 0, 0, 2'b00, 0, 0, 0);
      checkConst("fill_count", 32'(count), 8);
      checkConst("fill_spots", 32'(disp_spots), 0);
      checkConst("fill_tail_phase", 32'(disp_tail), 8);

      // Out-of-order completion, then retire all three.
      applyStimulus(0, 0, 0, 0, 2'b00, 0, 0, 1);
      applyStimulus(3, 0, 0, 0, 2'b00, 0, 0, 0);
      checkConst("ooo_avail_a", 32'(retire_avail), 0);
      applyStimulus(0, 0, 0, 0, 2'b11, 1, 2, 0);
      checkConst("ooo_avail_b", 32'(retire_avail), 0);
      applyStimulus(0, 0, 0, 0, 2'b01, 0, 0, 0);
      checkConst("ooo_avail_c", 32'(retire_avail), 3);
      applyStimulus(0, 3, 0, 0, 2'b00, 0, 0, 0);
      checkConst("ooo_count", 32'(count), 0);
      checkConst("ooo_head_tail", 32'(disp_tail), 3);

      // Move head to 5, then fill so that tail is 13 with phase set.
      applyStimulus(2, 0, 0, 0, 2'b00, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 2'b11, 3, 4, 0);
      applyStimulus(0, 2, 0, 0, 2'b00, 0, 0, 0);
      for (int n = 0; n < 3; n++) applyStimulus(m_spots(), 0, 0, 0, 2'b00, 0, 0, 0);
      checkConst("wrap_tail", 32'(disp_tail), 13);
      checkConst("wrap_count", 32'(count), 8);
      applyStimulus(0, 0, 1, 8, 2'b00, 0, 0, 0);
      checkConst("flush_full_count", 32'(count), 8);
      applyStimulus(0, 0, 1, 2, 2'b00, 0, 0, 0);
      checkConst("flush_two_count", 32'(count), 2);
      checkConst("flush_two_spots", 32'(disp_spots), 3);

      // Same-cycle dispatch, retire and completion of the head+1 slot.
      applyStimulus(0, 0, 0, 0, 2'b01, 5, 0, 0);
      applyStimulus(2, 1, 0, 0, 2'b01, 6, 0, 0);
      checkConst("mixed_count", 32'(count), 3);
      checkConst("mixed_avail", 32'(retire_avail), 1);

      // Reset while dispatch is requested empties the buffer.
      applyStimulus(3, 0, 0, 0, 2'b00, 0, 0, 1);
      checkConst("midreset_count", 32'(count), 0);

      // Random traffic within the protocol rules.
      for (int n = 0; n < 400; n++) begin
         int c;
         int dc;
         int rc;
         int fk;
         int ci0;
         int ci1;
         bit fv;
         bit rst;
         bit [1:0] cv;
         c   = m_count();
         dc  = $urandom_range(0, m_spots());
         rc  = $urandom_range(0, m_avail());
         fv  = ($urandom_range(0, 9) == 0);
         fk  = $urandom_range(rc, c);
         cv  = 2'b00;
         ci0 = 0;
         ci1 = 0;
         if (c > 0) begin
            cv  = 2'($urandom_range(0, 3));
            ci0 = (m_head + $urandom_range(0, c - 1)) % D;
            ci1 = (m_head + $urandom_range(0, c - 1)) % D;
         end
`ifdef ROB_EXCEPTION_EN
         cdb_exc = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
`endif
         rst = ($urandom_range(0, 149) == 0);
         applyStimulus(dc, rc, fv, fk, cv, ci0, ci1, rst);
      end

`ifdef ROB_EXCEPTION_EN
      // Entries 0..2 all done, entry 1 excepting.
      cdb_exc = 2'b00;
      applyStimulus(0, 0, 0, 0, 2'b00, 0, 0, 1);
      applyStimulus(3, 0, 0, 0, 2'b00, 0, 0, 0);
      cdb_exc = 2'b10;
      applyStimulus(0, 0, 0, 0, 2'b11, 0, 1, 0);
      cdb_exc = 2'b00;
      applyStimulus(0, 0, 0, 0, 2'b01, 2, 0, 0);
      checkConst("exc_avail", 32'(retire_avail), 2);
      checkConst("exc_flag", 32'(retire_exc), 1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
      $finish;
   end

endmodule
